// File: rtl/mips_fetch_unit_if.sv
// Bus bundle for the MIPS fetch stage: the instruction-memory read port,
// the redirect input from branch resolution and the decode-side output port.
//
// Handshakes:
//   imem: imem_req rises with a stable imem_addr and stays high, with the
//         address unchanged, until the cycle in which imem_ack=1. That cycle
//         completes the read and imem_rdata is sampled in it. imem_ack is
//         ignored while imem_req=0.
//   out:  an instruction moves to decode in a cycle where out_valid=1 and
//         out_ready=1. While out_valid=1 and out_ready=0, out_instr and out_pc
//         hold steady. out_valid is masked by redirect_valid in the same cycle.
interface mips_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;
    logic [31:0]        fetch_count;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        input  out_ready,
        output out_valid, out_instr, out_pc, out_pc_next, fetch_count
    );

    // Memory / branch unit / decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        output out_ready,
        input  out_valid, out_instr, out_pc, out_pc_next, fetch_count
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage. Owns the PC, keeps at most one read
// outstanding on the instruction memory, buffers one fetched instruction for
// decode, and follows redirects from branch resolution. A redirect that
// arrives while a read is still pending is remembered in pc and the pending
// read is drained (its data thrown away) before the new target is requested.
module mips_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    mips_fetch_unit_if.master bus,
    output logic [1:0]        state_dbg
);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  opc_q, opc_d;
    logic [ADDR_W-1:0]  opcn_q, opcn_d;
    logic [31:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    assign target = bus.redirect_pc & ALIGN_MASK;
    assign pc_inc = pc_q + STEP;

    // State and datapath registers; everything visible outside is registered
    // except out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            opcn_q  <= STEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opcn_q  <= opcn_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-datapath logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        opcn_d  = opcn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d    = bus.redirect_valid ? target : pc_q;
                addr_d  = bus.redirect_valid ? target : pc_q;
                state_d = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        // Wrong-path data: drop it and re-issue at the target.
                        pc_d   = target;
                        addr_d = target;
                    end else begin
                        instr_d = bus.imem_rdata;
                        opc_d   = pc_q;
                        opcn_d  = pc_inc;
                        pc_d    = pc_inc;
                        state_d = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // Address must not move mid-request, so only pc changes.
                    pc_d    = target;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_d = target;
                end
                if (bus.imem_ack) begin
                    addr_d  = bus.redirect_valid ? target : pc_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = target;
                    addr_d  = target;
                    state_d = REQ;
                end else if (bus.out_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.out_valid   = (state_q == HOLD) && !bus.redirect_valid;
    assign bus.out_instr   = instr_q;
    assign bus.out_pc      = opc_q;
    assign bus.out_pc_next = opcn_q;
    assign bus.fetch_count = cnt_q;
    assign state_dbg       = state_q;
endmodule
